// File: rtl/softmax_fp_pkg.sv
// rtl/softmax_fp_pkg.sv - FP32 field layout, constants and FSM encoding for the softmax divider
package softmax_fp_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP32_ZERO    = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DIV   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/fp32_div_core.sv
// rtl/fp32_div_core.sv - restoring mantissa divider, one quotient bit per cycle, MSB first
module fp32_div_core #(
  parameter int QUO_BITS = 25
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [23:0]         fn,
  input  logic [23:0]         fd,
  output logic [QUO_BITS-1:0] q,
  output logic                done
);
  localparam int CNT_W = $clog2(QUO_BITS);

  logic [24:0]      rem;
  logic [23:0]      dvs;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             ge;
  logic [24:0]      diff;

  always_comb begin
    ge   = rem >= {1'b0, dvs};
    diff = rem - {1'b0, dvs};
    done = busy && (cnt == CNT_W'(QUO_BITS - 1));
  end

  // The partial remainder stays below 2*fd, so the top bit is always free before the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      q    <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {1'b0, fn};
      dvs  <= fd;
      cnt  <= '0;
      q    <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      q   <= {q[QUO_BITS-2:0], ge};
      rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/softmax_normalizer_div.sv
// rtl/softmax_normalizer_div.sv - FP32 e_i / S divider with streaming numerators and truncated result
module softmax_normalizer_div
  import softmax_fp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int QUO_BITS   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_den,
  input  logic [DATA_WIDTH-1:0] den_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  div_by_zero
);
  localparam logic [30:0] INF_MAG = FP32_POS_INF[30:0];

  state_t state, state_n;
  logic [DATA_WIDTH-1:0] den_reg, num_q, dvs_q;
  logic                  accept, start, core_done;
  logic [QUO_BITS-1:0]   q;
  logic                  sgn, n_zero, d_zero;
  logic [7:0]            en, ed;
  logic signed [9:0]     e_raw, e_n;
  logic [MAN_W-1:0]      man;
  logic [DATA_WIDTH-1:0] norm_res;

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    sgn    = num_q[SIGN_BIT] ^ dvs_q[SIGN_BIT];
    en     = num_q[EXP_MSB:EXP_LSB];
    ed     = dvs_q[EXP_MSB:EXP_LSB];
    n_zero = (en == 8'd0);
    d_zero = (ed == 8'd0);
    e_raw  = 10'({2'b00, en}) - 10'({2'b00, ed}) + 10'(EXP_BIAS);
    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift normalises it.
    if (q[QUO_BITS-1]) begin
      man = q[QUO_BITS-2:1];
      e_n = e_raw;
    end else begin
      man = q[QUO_BITS-3:0];
      e_n = e_raw - 10'sd1;
    end
    if (e_n <= 10'sd0)        norm_res = {sgn, FP32_ZERO[30:0]};
    else if (e_n >= 10'sd255) norm_res = {sgn, INF_MAG};
    else                      norm_res = {sgn, e_n[7:0], man};
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_n = ST_CHECK;
      ST_CHECK: begin
        if (n_zero || d_zero) state_n = ST_DONE;
        else begin
          start   = 1'b1;
          state_n = ST_DIV;
        end
      end
      ST_DIV:   if (core_done) state_n = ST_NORM;
      ST_NORM:  state_n = ST_DONE;
      ST_DONE:  if (out_ready) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      den_reg     <= '0;
      num_q       <= '0;
      dvs_q       <= '0;
      out_data    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (load_den) begin
        den_reg     <= den_in;
        div_by_zero <= 1'b0;
      end
      if (accept) begin
        num_q <= in_data;
        dvs_q <= load_den ? den_in : den_reg;
      end
      if (state == ST_CHECK) begin
        if (n_zero) out_data <= {sgn, FP32_ZERO[30:0]};
        else if (d_zero) begin
          out_data    <= {sgn, INF_MAG};
          div_by_zero <= 1'b1;
        end
      end
      if (state == ST_NORM) out_data <= norm_res;
    end
  end

  fp32_div_core #(.QUO_BITS(QUO_BITS)) u_core (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .fn   ({1'b1, num_q[MAN_W-1:0]}),
    .fd   ({1'b1, dvs_q[MAN_W-1:0]}),
    .q    (q),
    .done (core_done)
  );
endmodule

// File: tb/tb_softmax_normalizer_div.sv
// tb/tb_softmax_normalizer_div.sv - directed and random checks of softmax_normalizer_div against an arithmetic model
module tb_softmax_normalizer_div;
  logic        clk = 1'b0;
  logic        rst, load_den, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [31:0] den_in, in_data, out_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] cur_den;
  logic        dbz_m;

  always #5 clk = ~clk;

  softmax_normalizer_div #(.DATA_WIDTH(32), .QUO_BITS(25)) dut (
    .clk(clk), .rst(rst), .load_den(load_den), .den_in(den_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mantissa quotient by plain integer division: floor(fN * 2^24 / fD).
  function automatic logic [31:0] ref_div(input logic [31:0] n, input logic [31:0] d);
    logic        s;
    int          en, ed, e;
    logic [47:0] num, qq;
    logic [24:0] q;
    s  = n[31] ^ d[31];
    en = int'(n[30:23]);
    ed = int'(d[30:23]);
    if (en == 0) return {s, 31'h0};
    if (ed == 0) return {s, 8'hFF, 23'h0};
    num = 48'({1'b1, n[22:0]}) << 24;
    qq  = num / 48'({1'b1, d[22:0]});
    q   = qq[24:0];
    e   = en - ed + 127;
    if (!q[24]) begin
      q = q << 1;
      e = e - 1;
    end
    if (e <= 0)   return {s, 31'h0};
    if (e >= 255) return {s, 8'hFF, 23'h0};
    return {s, e[7:0], q[23:1]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int   r;
    logic [7:0] ex;
    r = $urandom_range(0, 9);
    if (r == 0)      ex = 8'd0;
    else if (r == 1) ex = 8'($urandom_range(1, 254));
    else             ex = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
  endfunction

  // Caller is 1 time unit after a rising edge with the block idle.
  task automatic run_op(input string tag, input logic [31:0] num, input logic do_load,
                        input logic [31:0] den, input int hold);
    logic [31:0] exp;
    int          exp_lat, lat;
    if (do_load) begin
      cur_den = den;
      dbz_m   = 1'b0;
    end
    exp     = ref_div(num, cur_den);
    exp_lat = (num[30:23] == 8'd0 || cur_den[30:23] == 8'd0) ? 1 : 27;
    if (num[30:23] != 8'd0 && cur_den[30:23] == 8'd0) dbz_m = 1'b1;
    out_ready = (hold == 0);
    load_den  = do_load;
    den_in    = den;
    in_valid  = 1'b1;
    in_data   = num;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    load_den = 1'b0;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, out_data, exp);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(dbz_m));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held valid"}, 32'(out_valid), 32'd1);
      check({tag, " held data"}, out_data, exp);
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " handoff valid"}, 32'(out_valid), 32'd0);
    check({tag, " handoff in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; load_den = 1'b0; den_in = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cur_den = 32'h0; dbz_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", out_data, 32'h0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    #1;
    check("post rst in_ready", 32'(in_ready), 32'd1);

    run_op("t1 1/2", 32'h3F80_0000, 1'b1, 32'h4000_0000, 0);
    check("t1 value", ref_div(32'h3F80_0000, 32'h4000_0000), 32'h3F00_0000);
    run_op("t2 3/4", 32'h4040_0000, 1'b1, 32'h4080_0000, 0);
    run_op("t2 1/3", 32'h3F80_0000, 1'b1, 32'h4040_0000, 0);
    check("t2 value", ref_div(32'h3F80_0000, 32'h4040_0000), 32'h3EAA_AAAA);
    run_op("t3 +0", 32'h0000_0000, 1'b1, 32'h4000_0000, 0);
    run_op("t3 -0", 32'h8000_0000, 1'b0, 32'h0, 0);
    run_op("t4 div0", 32'hBF80_0000, 1'b1, 32'h0000_0000, 0);
    run_op("t4 sticky", 32'h3F80_0000, 1'b0, 32'h0, 0);
    run_op("t4 clear", 32'h3F80_0000, 1'b1, 32'h4000_0000, 0);
    run_op("t5 hold", 32'h4040_0000, 1'b0, 32'h0, 5);
    run_op("t5 next", 32'h3F80_0000, 1'b0, 32'h0, 0);

    // Abort mid-DIV; the reset divisor of zero is then observable on the next result.
    in_valid = 1'b1; in_data = 32'h3F80_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6 out_valid", 32'(out_valid), 32'd0);
    check("t6 in_ready during rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t6 in_ready", 32'(in_ready), 32'd1);
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    check("t6 no output", 32'(out_valid), 32'd0);
    cur_den = 32'h0; dbz_m = 1'b0;
    run_op("t6 den0", 32'h3F80_0000, 1'b0, 32'h0, 0);
    run_op("t6 redo", 32'h3F80_0000, 1'b1, 32'h4000_0000, 0);

    for (int k = 0; k < 40; k++) begin
      run_op($sformatf("rnd%0d", k), rnd_fp(), ($urandom_range(0, 3) != 0), rnd_fp(),
             ($urandom_range(0, 7) == 0) ? 2 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
